// File: rtl/spatz_pkg.sv
// Shared vector register file types and address helpers.
// Contents: sizing constants (NRVREG, NrVRFBanks), the element address
// (vreg_addr_t = {vreg, bank, elem}), the in-bank address
// (vregfile_addr_t = {vreg, elem}), data/byte-enable types, the queued write
// request struct, and the field extraction functions used by every block
// that decodes vector element addresses.
package spatz_pkg;

  localparam int unsigned NRVREG        = 32;
  localparam int unsigned NrVRFBanks    = 4;
  localparam int unsigned NrElemPerBank = 4;
  localparam int unsigned ELEN          = 32;

  localparam int unsigned VregIdxW = $clog2(NRVREG);
  localparam int unsigned BankIdxW = $clog2(NrVRFBanks);
  localparam int unsigned ElemIdxW = $clog2(NrElemPerBank);

  typedef logic [VregIdxW+BankIdxW+ElemIdxW-1:0] vreg_addr_t;
  typedef logic [VregIdxW+ElemIdxW-1:0]          vregfile_addr_t;
  typedef logic [ELEN-1:0]                       vreg_data_t;
  typedef logic [ELEN/8-1:0]                     vreg_be_t;

  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
  } vrf_wreq_t;

  // Bank index sits between the element bits and the vreg index.
  function automatic logic [BankIdxW-1:0] vaddr_bank(input vreg_addr_t a);
    return a[ElemIdxW +: BankIdxW];
  endfunction

  // In-bank address drops the bank field: {vreg, elem}.
  function automatic vregfile_addr_t vaddr_inbank(input vreg_addr_t a);
    return {a[ElemIdxW+BankIdxW +: VregIdxW], a[ElemIdxW-1:0]};
  endfunction

endpackage

// File: rtl/spatz_vrf_rr_arb.sv
// Per-bank NR_REQ-way round-robin arbiter with its own pointer register.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (pointer -> 0)
//   cand_i        : requesters whose FIFO head targets this bank
//   gnt_o         : one-hot grant (zero when no candidate)
// The first candidate at or after the pointer wins; the pointer then moves
// one past the winner, and holds when nothing is granted.
module spatz_vrf_rr_arb #(
  parameter int unsigned NR_REQ = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NR_REQ-1:0] cand_i,
  output logic [NR_REQ-1:0] gnt_o
);

  localparam int unsigned PtrW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PtrW-1:0] r_ptr, w_ptr_nxt;

  function automatic logic [PtrW-1:0] wrap(input int v);
    return PtrW'(v % int'(NR_REQ));
  endfunction

  // Scan from the farthest offset down so the nearest candidate to the
  // pointer is the last one written and therefore wins.
  always_comb begin
    gnt_o     = '0;
    w_ptr_nxt = r_ptr;
    for (int i = int'(NR_REQ) - 1; i >= 0; i--) begin
      if (cand_i[wrap(int'(r_ptr) + i)]) begin
        gnt_o                          = '0;
        gnt_o[wrap(int'(r_ptr) + i)]   = 1'b1;
        w_ptr_nxt                      = wrap(int'(r_ptr) + i + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ptr <= '0;
    else         r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/spatz_vrf_wsched.sv
// VRF write-port scheduler. Each write source (0 VFU, 1 LSU, 2 SLD) owns an
// in-order FIFO; every bank round-robins its single write port among the
// FIFO heads that target it.
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset (drops queued writes)
//   req_valid_i/ready_o: per-source push handshake, ready = FIFO not full
//   req_addr/data/be_i : element address {vreg,bank,elem}, data, byte enables
//   bank_we/waddr/wdata/wbe_o : per-bank write port, zero when not enabled
//   wdone_o            : per-source pulse, head written this cycle
//   busy_o             : any FIFO non-empty
// NR_BANKS must match the bank field width of vreg_addr_t (NrVRFBanks).
module spatz_vrf_wsched
  import spatz_pkg::*;
#(
  parameter int unsigned NR_REQ     = 3,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned NR_BANKS   = NrVRFBanks
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic           [NR_REQ-1:0]         req_valid_i,
  output logic           [NR_REQ-1:0]         req_ready_o,
  input  vreg_addr_t     [NR_REQ-1:0]         req_addr_i,
  input  vreg_data_t     [NR_REQ-1:0]         req_data_i,
  input  vreg_be_t       [NR_REQ-1:0]         req_be_i,
  output logic           [NR_BANKS-1:0]       bank_we_o,
  output vregfile_addr_t [NR_BANKS-1:0]       bank_waddr_o,
  output vreg_data_t     [NR_BANKS-1:0]       bank_wdata_o,
  output vreg_be_t       [NR_BANKS-1:0]       bank_wbe_o,
  output logic           [NR_REQ-1:0]         wdone_o,
  output logic                                busy_o
);

  // Pointers carry one extra wrap bit; depth 1 degenerates to a valid bit.
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 0;
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned AWI = (AW > 0) ? AW : 1;

  function automatic logic [AWI-1:0] slot(input logic [PW-1:0] p);
    if (AW == 0) return '0;
    return p[AWI-1:0];
  endfunction

  vrf_wreq_t [NR_REQ-1:0]               w_head;
  logic      [NR_REQ-1:0]               w_empty, w_full, w_pop;
  logic      [NR_BANKS-1:0][NR_REQ-1:0] w_cand, w_gnt;

  for (genvar r = 0; r < NR_REQ; r++) begin : g_fifo
    vrf_wreq_t       r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic            w_push;

    assign w_empty[r] = (r_wptr == r_rptr);
    assign w_full[r]  = ((r_wptr - r_rptr) == PW'(FIFO_DEPTH));
    // Ready depends only on registered state, never on this cycle's pop.
    assign w_push     = req_valid_i[r] & ~w_full[r];
    assign w_head[r]  = r_mem[slot(r_rptr)];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push)   r_wptr <= r_wptr + PW'(1);
        if (w_pop[r]) r_rptr <= r_rptr + PW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push) r_mem[slot(r_wptr)] <= '{addr: req_addr_i[r], data: req_data_i[r], be: req_be_i[r]};
    end
  end

  always_comb begin
    w_cand = '0;
    for (int b = 0; b < int'(NR_BANKS); b++)
      for (int r = 0; r < int'(NR_REQ); r++)
        w_cand[b][r] = ~w_empty[r] & (vaddr_bank(w_head[r].addr) == BankIdxW'(b));
  end

  for (genvar b = 0; b < NR_BANKS; b++) begin : g_arb
    spatz_vrf_rr_arb #(.NR_REQ(NR_REQ)) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .cand_i (w_cand[b]),
      .gnt_o  (w_gnt[b])
    );
  end

  // A head maps to one bank only, so each source sees at most one grant.
  always_comb begin
    bank_we_o    = '0;
    bank_waddr_o = '0;
    bank_wdata_o = '0;
    bank_wbe_o   = '0;
    wdone_o      = '0;
    for (int b = 0; b < int'(NR_BANKS); b++)
      for (int r = 0; r < int'(NR_REQ); r++)
        if (w_gnt[b][r]) begin
          bank_we_o[b]    = 1'b1;
          bank_waddr_o[b] = vaddr_inbank(w_head[r].addr);
          bank_wdata_o[b] = w_head[r].data;
          bank_wbe_o[b]   = w_head[r].be;
          wdone_o[r]      = 1'b1;
        end
  end

  assign w_pop       = wdone_o;
  assign req_ready_o = ~w_full;
  assign busy_o      = ~&w_empty;

endmodule

// File: tb/tb_spatz_vrf_wsched.sv
module tb_spatz_vrf_wsched;
  import spatz_pkg::*;

  localparam int NR = 3;
  localparam int NB = 4;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic           [NR-1:0]      valid;
  logic           [NR-1:0]      ready;
  vreg_addr_t     [NR-1:0]      addr;
  vreg_data_t     [NR-1:0]      data;
  vreg_be_t       [NR-1:0]      be_s;
  logic           [NB-1:0]      bank_we;
  vregfile_addr_t [NB-1:0]      bank_waddr;
  vreg_data_t     [NB-1:0]      bank_wdata;
  vreg_be_t       [NB-1:0]      bank_wbe;
  logic           [NR-1:0]      wdone;
  logic                         busy;

  always #5 clk = ~clk;

  spatz_vrf_wsched #(.NR_REQ(NR), .FIFO_DEPTH(2), .NR_BANKS(NB)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_addr_i   (addr),
    .req_data_i   (data),
    .req_be_i     (be_s),
    .bank_we_o    (bank_we),
    .bank_waddr_o (bank_waddr),
    .bank_wdata_o (bank_wdata),
    .bank_wbe_o   (bank_wbe),
    .wdone_o      (wdone),
    .busy_o       (busy)
  );

  int checks = 0;
  int errors = 0;
  vrf_wreq_t q0[$], q1[$], q2[$];
  logic [NR-1:0] acc;
  logic [2:0] rr_exp [6];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vreg_addr_t mkaddr(input int vreg, input int bank, input int elem);
    return {VregIdxW'(vreg), BankIdxW'(bank), ElemIdxW'(elem)};
  endfunction

  task automatic put(input int r, input int bank, input int vreg, input int elem,
                     input logic [31:0] d, input logic [3:0] b);
    valid[r] = 1'b1;
    addr[r]  = mkaddr(vreg, bank, elem);
    data[r]  = d;
    be_s[r]  = b;
  endtask

  // Pop the expected head of every source that reports a write and check
  // that its bank port carries exactly that entry.
  task automatic sb_check();
    vrf_wreq_t e;
    int nw;
    int bk;
    nw = 0;
    for (int r = 0; r < NR; r++) begin
      if (wdone[r]) begin
        nw++;
        case (r)
          0: begin chk("sb_q0_nonempty", 64'(q0.size() > 0), 64'd1); if (q0.size() > 0) e = q0.pop_front(); end
          1: begin chk("sb_q1_nonempty", 64'(q1.size() > 0), 64'd1); if (q1.size() > 0) e = q1.pop_front(); end
          default: begin chk("sb_q2_nonempty", 64'(q2.size() > 0), 64'd1); if (q2.size() > 0) e = q2.pop_front(); end
        endcase
        bk = int'(vaddr_bank(e.addr));
        chk("sb_we",    64'(bank_we[bk]), 64'd1);
        chk("sb_waddr", 64'(bank_waddr[bk]), 64'({e.addr[8:4], e.addr[1:0]}));
        chk("sb_wdata", 64'(bank_wdata[bk]), 64'(e.data));
        chk("sb_wbe",   64'(bank_wbe[bk]), 64'(e.be));
      end
    end
    chk("sb_we_count", 64'($countones(bank_we)), 64'(nw));
    for (int b = 0; b < NB; b++)
      if (!bank_we[b]) chk("idle_bank_zero", 64'({bank_waddr[b], bank_wdata[b], bank_wbe[b]}), 64'd0);
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_check();
    acc = valid & ready;
    if (acc[0]) q0.push_back('{addr: addr[0], data: data[0], be: be_s[0]});
    if (acc[1]) q1.push_back('{addr: addr[1], data: data[1], be: be_s[1]});
    if (acc[2]) q2.push_back('{addr: addr[2], data: data[2], be: be_s[2]});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && busy; i++) cycle();
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_sb_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid = '0; addr = '0; data = '0; be_s = '0;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready",  64'(ready), 64'b111);
    chk("rst_we",     64'(bank_we), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_wdone",  64'(wdone), 64'd0);
    chk("rst_bankout", 64'(|{bank_waddr, bank_wdata, bank_wbe}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single source, bank 0 then bank 1 back to back.
    put(0, 0, 3, 1, 32'h0000_0001, 4'hF);
    cycle();
    put(0, 1, 4, 2, 32'h0000_0002, 4'h5);
    chk("single_we0", 64'(bank_we), 64'b0001);
    chk("single_wdone0", 64'(wdone), 64'b001);
    cycle();
    valid = '0;
    chk("single_we1", 64'(bank_we), 64'b0010);
    chk("single_wdone1", 64'(wdone), 64'b001);
    cycle();
    chk("single_idle_we", 64'(bank_we), 64'd0);
    drain();

    // Three-way contention on bank 2.
    for (int r = 0; r < NR; r++) put(r, 2, r + 1, 0, 32'h0100_0000 * (r + 1) + 32'h10, 4'h1 << r);
    cycle();
    chk("rr_0", 64'(wdone), 64'(rr_exp[0]));
    for (int r = 0; r < NR; r++) put(r, 2, r + 8, 3, 32'h0100_0000 * (r + 1) + 32'h20, 4'hF);
    cycle();
    valid = '0;
    chk("rr_1", 64'(wdone), 64'(rr_exp[1]));
    for (int k = 2; k < 6; k++) begin
      cycle();
      chk("rr_seq", 64'(wdone), 64'(rr_exp[k]));
    end
    drain();

    // Parallel writes to banks 0, 1, 3.
    put(0, 0, 5, 0, 32'hA000_0000, 4'h1);
    put(1, 1, 6, 1, 32'hB000_0000, 4'h3);
    put(2, 3, 7, 2, 32'hC000_0000, 4'hC);
    cycle();
    valid = '0;
    chk("par_we",    64'(bank_we), 64'b1011);
    chk("par_d0",    64'(bank_wdata[0]), 64'hA000_0000);
    chk("par_d1",    64'(bank_wdata[1]), 64'hB000_0000);
    chk("par_d3",    64'(bank_wdata[3]), 64'hC000_0000);
    chk("par_be3",   64'(bank_wbe[3]), 64'hC);
    chk("par_addr3", 64'(bank_waddr[3]), 64'({5'd7, 2'd2}));
    chk("par_wdone", 64'(wdone), 64'b111);
    drain();

    // Full LSU FIFO while bank 1 is contended (bank 1 pointer now at 2).
    put(0, 1, 10, 0, 32'h0100_0100, 4'hF);
    put(1, 1, 11, 0, 32'h0200_0100, 4'hF);
    put(2, 1, 12, 0, 32'h0300_0100, 4'hF);
    cycle();
    chk("full_gnt_e1", 64'(wdone), 64'b100);
    put(0, 1, 10, 1, 32'h0100_0101, 4'hE);
    put(1, 1, 11, 1, 32'h0200_0101, 4'hD);
    put(2, 1, 12, 1, 32'h0300_0101, 4'hB);
    cycle();
    chk("full_ready_e2", 64'(ready), 64'b100);
    chk("full_gnt_e2", 64'(wdone), 64'b001);
    valid = '0;
    put(1, 1, 11, 2, 32'h0200_0102, 4'h7);
    cycle();
    chk("full_noacc_e3", 64'(acc[1]), 64'd0);
    chk("full_ready_e3", 64'(ready), 64'b101);
    cycle();
    chk("full_noacc_e4", 64'(acc[1]), 64'd0);
    chk("full_ready_e4", 64'(ready), 64'b111);
    cycle();
    chk("full_acc_e5", 64'(acc[1]), 64'd1);
    valid = '0;
    drain();

    // Reset with two queued entries.
    put(0, 3, 1, 0, 32'hDEAD_0000, 4'hF);
    put(1, 3, 2, 0, 32'hDEAD_0001, 4'hF);
    cycle();
    valid = '0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    64'(bank_we), 64'd0);
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'b111);
    chk("mid_rst_wdone", 64'(wdone), 64'd0);
    q0.delete(); q1.delete(); q2.delete();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_we",   64'(bank_we), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
